// File: rtl/timer_dev_if.sv
// Word-addressed register bus between the system bridge and a timer instance.
// The bridge drives address, full-word write strobe and data; the timer answers with read data.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, output we, output wd, input rd);
  modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/timer_dev.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Three word registers (CTRL, PRESET, COUNT); irq is the expiry flag gated by CTRL.IM.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter logic [31:0] CTRL_MASK  = 32'h0000_000F
) (
  input  logic       clk,
  input  logic       reset_n,
  timer_dev_if.slave bus,
  output logic       irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        en_s;
  logic [1:0]  mode_s;
  logic        flag_set_s;
  logic        flag_clr_s;
  logic        en_clr_s;

  assign wr_ctrl_s   = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_preset_s = bus.we && (bus.addr == ADDR_PRESET);
  assign en_s        = ctrl_q[0];
  assign mode_s      = ctrl_q[2:1];

  // Sequencer next state and counter update
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    flag_set_s = 1'b0;
    flag_clr_s = 1'b0;
    en_clr_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_s) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Presets 0 and 1 both expire on the first counting cycle
          count_d    = 32'd0;
          flag_set_s = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_s == MODE_RELOAD) begin
          flag_clr_s = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          en_clr_s = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register file next values; CPU writes win over the sequencer except for a flag set
  always_comb begin
    if (wr_ctrl_s) begin
      ctrl_d = bus.wd & CTRL_MASK;
    end else if (en_clr_s) begin
      ctrl_d = {ctrl_q[31:1], 1'b0};
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_preset_s) begin
      preset_d = bus.wd;
    end else begin
      preset_d = preset_q;
    end

    if (flag_set_s) begin
      flag_d = 1'b1;
    end else if (wr_ctrl_s || wr_preset_s || flag_clr_s) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 32'h0000_0000;
      preset_q <= PRESET_RST;
      count_q  <= 32'h0000_0000;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Read data mux; the reserved word reads as zero
  always_comb begin
    case (bus.addr)
      ADDR_CTRL:   bus.rd = ctrl_q & CTRL_MASK;
      ADDR_PRESET: bus.rd = preset_q;
      ADDR_COUNT:  bus.rd = count_q;
      default:     bus.rd = 32'h0000_0000;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: vector table, directed corner sequences and
// randomized bus traffic checked against a phase/elapsed-tick reference model.
module tb_timer_dev;

  logic clk = 1'b0;
  logic reset_n;
  logic irq;

  timer_dev_if bus();

  timer_dev #(
    .PRESET_RST(32'h0000_0000),
    .CTRL_MASK (32'h0000_000F)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase of the timer, value latched at load, ticks elapsed since load
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_EXP  = 3;
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_load;
  logic [31:0] m_ticks;
  logic        m_flag;

  function automatic logic [31:0] m_count();
    return (m_load > m_ticks) ? (m_load - m_ticks) : 32'd0;
  endfunction

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_ctrl   = 4'h0;
    m_preset = 32'h0000_0000;
    m_load   = 32'd0;
    m_ticks  = 32'd0;
    m_flag   = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic cpu_ctrl, cpu_pre, set_f, clr_f, drop_en;
    int   nphase;
    cpu_ctrl = we && (a == 2'd0);
    cpu_pre  = we && (a == 2'd1);
    set_f = 1'b0; clr_f = 1'b0; drop_en = 1'b0;
    nphase = m_phase;
    if (m_phase == PH_IDLE) begin
      if (m_ctrl[0]) nphase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      m_load = m_preset; m_ticks = 32'd0; nphase = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (!m_ctrl[0]) nphase = PH_IDLE;
      else if (m_count() > 32'd1) m_ticks = m_ticks + 32'd1;
      else begin m_ticks = m_load; set_f = 1'b1; nphase = PH_EXP; end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin clr_f = 1'b1; nphase = PH_LOAD; end
      else begin drop_en = 1'b1; nphase = PH_IDLE; end
    end
    m_phase = nphase;
    if (cpu_pre) m_preset = d;
    if (cpu_ctrl) m_ctrl = d[3:0];
    else if (drop_en) m_ctrl[0] = 1'b0;
    if (set_f) m_flag = 1'b1;
    else if (cpu_ctrl || cpu_pre || clr_f) m_flag = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rd;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    chk({tag, " irq"}, {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
    peek(2'd0, v); chk({tag, " ctrl"}, v, {28'd0, m_ctrl});
    peek(2'd1, v); chk({tag, " preset"}, v, m_preset);
    peek(2'd2, v); chk({tag, " count"}, v, m_count());
    peek(2'd3, v); chk({tag, " rsvd"}, v, 32'h0000_0000);
  endtask

  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
    bus.we = we; bus.addr = a; bus.wd = d;
    @(posedge clk);
    model_step(we, a, d);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic step(input string tag, input logic we, input logic [1:0] a, input logic [31:0] d);
    cyc(we, a, d);
    check_state(tag);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          pulses, last_t, found;
    logic        prev_irq;

    // One-shot, PRESET=5, CTRL=0x9: counts 5..1, expires two edges after COUNT reads 1 minus one
    tbl[0]  = '{1'b1, 2'd1, 32'd5, 32'h0, 32'd5, 32'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 32'h9, 32'h9, 32'd5, 32'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd5, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd4, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd3, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd2, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 32'h0, 32'h9, 32'd5, 32'd0, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 32'h0, 32'h8, 32'd5, 32'd0, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 32'h0, 32'h8, 32'd5, 32'd0, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 32'h8, 32'h8, 32'd5, 32'd0, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 32'h0, 32'h8, 32'd5, 32'd0, 1'b0};

    bus.we = 1'b0; bus.addr = 2'd0; bus.wd = 32'h0;
    reset_n = 1'b0;
    model_reset();
    #3;
    check_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].we, tbl[i].addr, tbl[i].wd);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
      peek(2'd0, v); chk($sformatf("vec%0d ctrl", i), v, tbl[i].ctrl);
      peek(2'd1, v); chk($sformatf("vec%0d preset", i), v, tbl[i].preset);
      peek(2'd2, v); chk($sformatf("vec%0d count", i), v, tbl[i].count);
    end

    // Auto-reload: one-cycle pulses every P+2 cycles, EN stays set
    step("ar_pre", 1'b1, 2'd1, 32'd3);
    step("ar_ctl", 1'b1, 2'd0, 32'hB);
    pulses = 0; last_t = 0; prev_irq = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step("ar_run", 1'b0, 2'd0, 32'h0);
      if (irq) begin
        chk("ar width", {31'd0, prev_irq}, 32'd0);
        chk("ar gap", (k - last_t), ((pulses == 0) ? 32'd5 : 32'd5));
        pulses++; last_t = k;
      end
      prev_irq = irq;
    end
    chk("ar pulses", pulses, 32'd8);
    peek(2'd0, v); chk("ar en", {31'd0, v[0]}, 32'd1);

    // Asynchronous reset while irq is high
    #2;
    reset_n = 1'b0;
    #1;
    chk("async irq", {31'd0, irq}, 32'd0);
    model_reset();
    check_state("async");
    @(negedge clk);
    reset_n = 1'b1;

    // Masked expiry; enabling IM on the expiry edge keeps the flag (set wins)
    step("sw_pre", 1'b1, 2'd1, 32'd2);
    step("sw_ctl", 1'b1, 2'd0, 32'h1);
    for (int k = 0; k < 3; k++) step("sw_run", 1'b0, 2'd0, 32'h0);
    step("sw_im", 1'b1, 2'd0, 32'h9);
    chk("setwins irq", {31'd0, irq}, 32'd1);
    step("sw_int", 1'b0, 2'd0, 32'h0);
    peek(2'd0, v); chk("oneshot en clr", v, 32'h8);
    step("sw_clr", 1'b1, 2'd0, 32'h8);
    chk("wrclr irq", {31'd0, irq}, 32'd0);

    // Masked run: irq never rises, CTRL write with IM clears pending flag
    step("mk_ctl", 1'b1, 2'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      step("mk_run", 1'b0, 2'd0, 32'h0);
      chk("mask irq", {31'd0, irq}, 32'd0);
    end
    step("mk_im", 1'b1, 2'd0, 32'h8);
    chk("mask clr irq", {31'd0, irq}, 32'd0);

    // Stop mid-count at 7
    step("st_pre", 1'b1, 2'd1, 32'd20);
    step("st_ctl", 1'b1, 2'd0, 32'h1);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      peek(2'd2, v);
      if (v == 32'd8) found = 1;
      else step("st_run", 1'b0, 2'd0, 32'h0);
    end
    chk("stop reach8", found, 32'd1);
    step("st_off", 1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step("st_hold", 1'b0, 2'd0, 32'h0);
      peek(2'd2, v); chk("stop hold", v, 32'd7);
    end

    // PRESET 0 and 1: one counting cycle, then expiry with COUNT 0
    for (int p = 0; p < 2; p++) begin
      step("ev_pre", 1'b1, 2'd1, p);
      step("ev_ctl", 1'b1, 2'd0, 32'h9);
      step("ev_a", 1'b0, 2'd0, 32'h0);
      step("ev_b", 1'b0, 2'd0, 32'h0);
      chk("edge noirq", {31'd0, irq}, 32'd0);
      step("ev_c", 1'b0, 2'd0, 32'h0);
      chk("edge irq", {31'd0, irq}, 32'd1);
      peek(2'd2, v); chk("edge count", v, 32'd0);
      step("ev_d", 1'b0, 2'd0, 32'h0);
      step("ev_e", 1'b1, 2'd0, 32'h0);
    end

    // Maximum preset, ignored writes to COUNT/reserved, PRESET write mid-count
    step("mx_pre", 1'b1, 2'd1, 32'hFFFF_FFFF);
    step("mx_ctl", 1'b1, 2'd0, 32'h1);
    step("mx_a", 1'b0, 2'd0, 32'h0);
    step("mx_b", 1'b0, 2'd0, 32'h0);
    peek(2'd2, v); chk("max load", v, 32'hFFFF_FFFF);
    step("mx_c", 1'b0, 2'd0, 32'h0);
    peek(2'd2, v); chk("max dec", v, 32'hFFFF_FFFE);
    step("bus_cnt", 1'b1, 2'd2, 32'h1234_5678);
    peek(2'd2, v); chk("wr count ign", v, 32'hFFFF_FFFD);
    step("bus_rsv", 1'b1, 2'd3, 32'hDEAD_BEEF);
    peek(2'd3, v); chk("rsvd read", v, 32'h0);
    step("bus_pre", 1'b1, 2'd1, 32'd7);
    peek(2'd2, v); chk("pre midcount", v, 32'hFFFF_FFFB);
    step("mx_off", 1'b1, 2'd0, 32'h0);

    // Randomized bus traffic
    for (int k = 0; k < 500; k++) begin
      logic        rw;
      logic [1:0]  ra;
      logic [31:0] rdv;
      rw  = ($urandom_range(0, 7) == 0);
      ra  = 2'($urandom_range(0, 3));
      rdv = $urandom;
      if (ra == 2'd1) rdv = $urandom_range(0, 6);
      if (ra == 2'd0 && $urandom_range(0, 3) != 0) rdv[0] = 1'b1;
      step("rand", rw, ra, rdv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
